// File: rtl/pipe_stage_elastic_pkg.sv
// pipe_stage_elastic_pkg: occupancy state encoding and stage payload types for the elastic pipeline register.
//  pipe_occ_e     : EMPTY/ONE/FULL, encoded so it reads directly as an entry count
//  execute_data_t : EX/MEM payload carried by pipe_stage_elastic #(.T(execute_data_t))
package pipe_stage_elastic_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} pipe_occ_e;
  typedef struct packed {
    logic [63:0] alu;
    logic [4:0]  rd;
    logic        wb_en;
  } execute_data_t;
endpackage

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline register with flush and optional two-entry skid.
//  clk, reset (async active-high) | in_valid, in_ready, in_data : upstream handshake
//  flush : squash held entries | out_valid, out_ready, out_data : downstream handshake
//  occupancy : registered entry count (0..2, max 1 when SKID=0)
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter type T    = logic [63:0],
  parameter bit  SKID = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  T           in_data,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output T           out_data,
  output logic [1:0] occupancy
);
  pipe_occ_e state, nxt;
  T main_q, skid_q;
  logic rdy_q, push, pop;
  assign out_valid = state != EMPTY;
  assign out_data  = main_q;
  assign occupancy = state;
  // With the skid, in_ready is a flop so out_ready never reaches upstream combinationally.
  assign in_ready  = SKID ? rdy_q : (!out_valid || out_ready);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  always_comb begin
    nxt = state;
    if (flush) nxt = EMPTY;
    else if (state == EMPTY) nxt = push ? ONE : EMPTY;
    else if (state == ONE) nxt = (push && !pop && SKID) ? FULL : (pop && !push) ? EMPTY : ONE;
    else nxt = pop ? ONE : FULL;
  end
  // Data registers are gated by state only; flush leaves them alone since valid masks them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= EMPTY;
      rdy_q  <= 1'b1;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= nxt;
      rdy_q <= nxt != FULL;
      if (state == FULL) begin
        if (pop) main_q <= skid_q;
      end else if (push && (state == EMPTY || pop)) main_q <= in_data;
      else if (push) skid_q <= in_data;
    end
  end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: directed and scoreboarded checks of pipe_stage_elastic in skid and single-entry builds.
module tb_pipe_stage_elastic;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic v1 = 1'b0, r1 = 1'b0, f1 = 1'b0, ir1, ov1;
  logic [63:0] d1 = '0, od1;
  logic [1:0] oc1;
  logic v0 = 1'b0, r0 = 1'b0, f0 = 1'b0, ir0, ov0;
  logic [63:0] d0 = '0, od0;
  logic [1:0] oc0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic #(.SKID(1'b1)) u_skid (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(ir1), .in_data(d1), .flush(f1),
    .out_valid(ov1), .out_ready(r1), .out_data(od1), .occupancy(oc1)
  );

  pipe_stage_elastic #(.SKID(1'b0)) u_single (
    .clk(clk), .reset(reset), .in_valid(v0), .in_ready(ir0), .in_data(d0), .flush(f0),
    .out_valid(ov0), .out_ready(r0), .out_data(od0), .occupancy(oc0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests += 6;
    if (ov1 !== 1'b0) begin fails++; $display("FAIL reset_ov1 got %b want 0", ov1); end
    if (od1 !== 64'h0) begin fails++; $display("FAIL reset_od1 got %h want 0", od1); end
    if (oc1 !== 2'd0) begin fails++; $display("FAIL reset_oc1 got %0d want 0", oc1); end
    if (ir1 !== 1'b1) begin fails++; $display("FAIL reset_ir1 got %b want 1", ir1); end
    if (ov0 !== 1'b0) begin fails++; $display("FAIL reset_ov0 got %b want 0", ov0); end
    if (ir0 !== 1'b1) begin fails++; $display("FAIL reset_ir0 got %b want 1", ir0); end
  endtask

  task automatic test_back_to_back();
    r1 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      v1 = 1'b1;
      d1 = 64'(i);
      tick();
      tests += 3;
      if (od1 !== 64'(i)) begin fails++; $display("FAIL b2b_data[%0d] got %h want %h", i, od1, i); end
      if (ov1 !== 1'b1) begin fails++; $display("FAIL b2b_valid[%0d] got %b want 1", i, ov1); end
      if (ir1 !== 1'b1 || oc1 !== 2'd1) begin
        fails++; $display("FAIL b2b_occ[%0d] got ir=%b occ=%0d want ir=1 occ=1", i, ir1, oc1);
      end
    end
    v1 = 1'b0;
    tick();
    tests++;
    if (ov1 !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b want 0", ov1); end
  endtask

  task automatic test_skid_fill();
    r1 = 1'b0;
    v1 = 1'b1;
    d1 = 64'hA;
    tick();
    d1 = 64'hB;
    tick();
    v1 = 1'b0;
    tests += 3;
    if (oc1 !== 2'd2) begin fails++; $display("FAIL fill_occ got %0d want 2", oc1); end
    if (ir1 !== 1'b0) begin fails++; $display("FAIL fill_ready got %b want 0", ir1); end
    if (od1 !== 64'hA) begin fails++; $display("FAIL fill_data got %h want a", od1); end
    tick();
    tests++;
    if (od1 !== 64'hA || ov1 !== 1'b1) begin
      fails++; $display("FAIL fill_hold got v=%b d=%h want v=1 d=a", ov1, od1);
    end
    r1 = 1'b1;
    tick();
    tests++;
    if (od1 !== 64'hB || oc1 !== 2'd1 || ir1 !== 1'b1) begin
      fails++; $display("FAIL fill_second got d=%h occ=%0d ir=%b want d=b occ=1 ir=1", od1, oc1, ir1);
    end
    tick();
    tests++;
    if (ov1 !== 1'b0 || oc1 !== 2'd0) begin
      fails++; $display("FAIL fill_empty got v=%b occ=%0d want v=0 occ=0", ov1, oc1);
    end
  endtask

  task automatic test_flush();
    r1 = 1'b0;
    v1 = 1'b1;
    d1 = 64'h11;
    tick();
    d1 = 64'h12;
    tick();
    tests++;
    if (oc1 !== 2'd2) begin fails++; $display("FAIL flush_pre got occ=%0d want 2", oc1); end
    f1 = 1'b1;
    d1 = 64'hC;
    tick();
    f1 = 1'b0;
    v1 = 1'b0;
    tests += 3;
    if (ov1 !== 1'b0) begin fails++; $display("FAIL flush_valid got %b want 0", ov1); end
    if (oc1 !== 2'd0) begin fails++; $display("FAIL flush_occ got %0d want 0", oc1); end
    if (ir1 !== 1'b1) begin fails++; $display("FAIL flush_ready got %b want 1", ir1); end
    r1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (ov1 !== 1'b0) begin fails++; $display("FAIL flush_leak[%0d] got v=%b d=%h want v=0", i, ov1, od1); end
    end
  endtask

  task automatic test_push_pop_one();
    r1 = 1'b0;
    v1 = 1'b1;
    d1 = 64'h4;
    tick();
    tests++;
    if (oc1 !== 2'd1 || od1 !== 64'h4) begin
      fails++; $display("FAIL pp_pre got occ=%0d d=%h want occ=1 d=4", oc1, od1);
    end
    d1 = 64'h5;
    r1 = 1'b1;
    tick();
    v1 = 1'b0;
    tests += 2;
    if (oc1 !== 2'd1) begin fails++; $display("FAIL pp_occ got %0d want 1", oc1); end
    if (od1 !== 64'h5) begin fails++; $display("FAIL pp_data got %h want 5", od1); end
    tick();
    tests++;
    if (ov1 !== 1'b0) begin fails++; $display("FAIL pp_drain got %b want 0", ov1); end
  endtask

  task automatic test_single_random();
    logic [63:0] q[$];
    int pushes = 0;
    int budget = 20000;
    bit push, pop;
    while (pushes < 1000 && budget > 0) begin
      budget--;
      v0 = 1'($urandom_range(0, 1));
      d0 = {$urandom, $urandom};
      r0 = $urandom_range(0, 3) != 0;
      #1;
      tests += 2;
      if (ir0 !== (!ov0 || r0)) begin fails++; $display("FAIL single_ready got %b want %b", ir0, !ov0 || r0); end
      if (ov0 !== (q.size() != 0)) begin fails++; $display("FAIL single_valid got %b want %b", ov0, q.size() != 0); end
      push = v0 && (q.size() == 0 || r0);
      pop = q.size() != 0 && r0;
      if (pop) begin
        tests++;
        if (od0 !== q[0]) begin fails++; $display("FAIL single_data got %h want %h", od0, q[0]); end
        void'(q.pop_front());
      end
      if (push) begin
        q.push_back(d0);
        pushes++;
      end
      tick();
    end
    tests++;
    if (pushes != 1000) begin fails++; $display("FAIL single_budget got %0d pushes want 1000", pushes); end
    v0 = 1'b0;
    r0 = 1'b1;
    budget = 10;
    while (q.size() != 0 && budget > 0) begin
      budget--;
      #1;
      tests++;
      if (ov0 !== 1'b1 || od0 !== q[0]) begin
        fails++; $display("FAIL single_drain got v=%b d=%h want v=1 d=%h", ov0, od0, q[0]);
      end
      void'(q.pop_front());
      tick();
    end
    tests++;
    if (ov0 !== 1'b0 || q.size() != 0) begin
      fails++; $display("FAIL single_end got v=%b left=%0d want v=0 left=0", ov0, q.size());
    end
  endtask

  task automatic test_reset_midstream();
    r1 = 1'b0;
    v1 = 1'b1;
    d1 = 64'h21;
    tick();
    d1 = 64'h22;
    tick();
    v1 = 1'b0;
    tests++;
    if (oc1 !== 2'd2) begin fails++; $display("FAIL rst_pre got occ=%0d want 2", oc1); end
    reset = 1'b1;
    #1;
    tests += 2;
    if (ov1 !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", ov1); end
    if (oc1 !== 2'd0) begin fails++; $display("FAIL rst_occ got %0d want 0", oc1); end
    tick();
    reset = 1'b0;
    tick();
    tests += 2;
    if (ir1 !== 1'b1) begin fails++; $display("FAIL rst_ready got %b want 1", ir1); end
    if (ov1 !== 1'b0 || od1 !== 64'h0) begin
      fails++; $display("FAIL rst_after got v=%b d=%h want v=0 d=0", ov1, od1);
    end
  endtask

  initial begin
    #12;
    test_reset();
    reset = 1'b0;
    tick();
    test_back_to_back();
    test_skid_fill();
    test_flush();
    test_push_pop_one();
    test_single_random();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
